muldiv_unit: RTL and testbench

- Iterative unsigned multiply/divide execution unit downstream of the two-read-port register file.
- Captures the datA_out/datB_out operands and the destination register address on a start pulse.
- Iterates one bit per clock, then issues a single-cycle write-back (wr_en, wr_addr, dat_out) that drives the register file write port directly.
- Lets the 8-bit core support MUL/DIV without a wide combinational multiplier or divider.

---
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: one bit per clock,
// single-cycle register-file write-back on completion.
module muldiv_unit #(
    parameter int dw = 8,
    parameter int pw = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [dw-1:0] opA,
    input  logic [dw-1:0] opB,
    input  logic [pw-1:0] dst_addr,
    output logic          busy,
    output logic          wr_en,
    output logic [pw-1:0] wr_addr,
    output logic [dw-1:0] dat_out
);

    localparam int CW = (dw > 1) ? $clog2(dw) : 1;
    localparam logic [CW-1:0] LAST = CW'(dw - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*dw-1:0] acc_q, acc_d;
    logic [dw-1:0]   a_q, a_d;
    logic [dw-1:0]   b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic [pw-1:0]   dst_q, dst_d;
    logic            busy_q, busy_d;
    logic            wr_en_q, wr_en_d;
    logic [pw-1:0]   wr_addr_q, wr_addr_d;
    logic [dw-1:0]   dat_out_q, dat_out_d;

    logic [dw:0]     mul_add;
    logic [2*dw-1:0] mul_next;
    logic [dw:0]     div_shift;
    logic [dw:0]     div_diff;
    logic [dw-1:0]   div_rem;
    logic [2*dw-1:0] div_next;
    logic [2*dw-1:0] acc_step;
    logic [dw-1:0]   step_res;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {remainder, dividend bits / quotient bits}.
    always_comb begin
        mul_add   = {1'b0, acc_q[2*dw-1:dw]}
                  + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next  = {mul_add, acc_q[dw-1:1]};
        div_shift = {acc_q[2*dw-1:dw], acc_q[dw-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_rem   = div_diff[dw] ? div_shift[dw-1:0]
                                 : div_diff[dw-1:0];
        div_next  = {div_rem, acc_q[dw-2:0], ~div_diff[dw]};
        acc_step  = op_q[1] ? div_next : mul_next;
        step_res  = op_q[0] ? acc_step[2*dw-1:dw]
                            : acc_step[dw-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        dst_d     = dst_q;
        wr_addr_d = wr_addr_q;
        dat_out_d = dat_out_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d   = opA;
                    b_d   = opB;
                    op_d  = op;
                    dst_d = dst_addr;
                    cnt_d = '0;
                    if (op[1] && (opB == '0)) begin
                        state_d   = S_WB;
                        wr_addr_d = dst_addr;
                        dat_out_d = op[0] ? opA : '1;
                    end else begin
                        state_d = S_RUN;
                        acc_d   = op[1] ? {{dw{1'b0}}, opA}
                                        : {{dw{1'b0}}, opB};
                    end
                end
            end
            S_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d   = S_WB;
                    wr_addr_d = dst_q;
                    dat_out_d = step_res;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d  = (state_d != S_IDLE);
        wr_en_d = (state_d == S_WB);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            dst_q     <= '0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            dat_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            dst_q     <= dst_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            dat_out_q <= dat_out_d;
        end
    end

    assign busy    = busy_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign dat_out = dat_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit.
module tb_muldiv_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic [7:0] opA;
    logic [7:0] opB;
    logic [1:0] dst_addr;
    logic       busy;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] dat_out;

    int errors = 0;
    int checks = 0;
    int lat;
    int pulses;

    localparam logic [1:0] MULLO = 2'b00;
    localparam logic [1:0] MULHI = 2'b01;
    localparam logic [1:0] DIVQ  = 2'b10;
    localparam logic [1:0] DIVR  = 2'b11;

    muldiv_unit #(.dw(8), .pw(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .opA      (opA),
        .opB      (opB),
        .dst_addr (dst_addr),
        .busy     (busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .dat_out  (dat_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait for write-back, check latency/data/addr/return to idle.
    task automatic do_op(input logic [1:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic [1:0] d,
                         input logic [7:0] exp, input int exp_lat,
                         input string tag);
        int n;
        @(negedge clk);
        op = o; opA = a; opB = b; dst_addr = d; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = ~o; opA = ~a; opB = 8'h5A; dst_addr = ~d;
        chk({tag, "_busy0"}, 32'(busy), 32'd1);
        n = 0;
        while (!wr_en && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_dat"}, 32'(dat_out), 32'(exp));
        chk({tag, "_addr"}, 32'(wr_addr), 32'(d));
        chk({tag, "_busywb"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, "_wrend"}, 32'(wr_en), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_hold"}, 32'(dat_out), 32'(exp));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = '0;
        opA = '0; opB = '0; dst_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wren", 32'(wr_en), 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_dat", 32'(dat_out), 32'd0);

        do_op(MULLO, 8'd13,  8'd11,  2'd1, 8'h8F, 8, "mullo13x11");
        do_op(MULLO, 8'd200, 8'd3,   2'd2, 8'h58, 8, "mullo200x3");
        do_op(MULHI, 8'd200, 8'd3,   2'd3, 8'h02, 8, "mulhi200x3");
        do_op(MULLO, 8'hFF,  8'hFF,  2'd0, 8'h01, 8, "mulloFF");
        do_op(MULHI, 8'hFF,  8'hFF,  2'd1, 8'hFE, 8, "mulhiFF");
        do_op(DIVQ,  8'd200, 8'd7,   2'd2, 8'h1C, 8, "divq200_7");
        do_op(DIVR,  8'd200, 8'd7,   2'd3, 8'h04, 8, "divr200_7");
        do_op(DIVQ,  8'd5,   8'd9,   2'd1, 8'h00, 8, "divq5_9");
        do_op(DIVR,  8'd5,   8'd9,   2'd2, 8'h05, 8, "divr5_9");
        do_op(DIVQ,  8'hFF,  8'h80,  2'd0, 8'h01, 8, "divqFF_80");
        do_op(DIVR,  8'hFF,  8'h80,  2'd3, 8'h7F, 8, "divrFF_80");
        do_op(DIVQ,  8'h55,  8'h00,  2'd1, 8'hFF, 0, "divq0");
        do_op(DIVR,  8'h55,  8'h00,  2'd2, 8'h55, 0, "divr0");

        // Starts during RUN and on the WB cycle must be ignored.
        @(negedge clk);
        op = MULLO; opA = 8'd13; opB = 8'd11; dst_addr = 2'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        op = DIVQ; opA = 8'h55; opB = 8'h00; dst_addr = 2'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 4;
        while (!wr_en && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("ign_lat", 32'(lat), 32'd8);
        chk("ign_dat", 32'(dat_out), 32'h8F);
        chk("ign_addr", 32'(wr_addr), 32'd2);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ign_wb_idle", 32'(busy), 32'd0);
        pulses = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (wr_en) pulses++;
        end
        chk("ign_pulses", 32'(pulses), 32'd0);
        do_op(MULHI, 8'd200, 8'd3, 2'd1, 8'h02, 8, "after_ign");

        // Reset in the middle of RUN.
        @(negedge clk);
        op = MULLO; opA = 8'd9; opB = 8'd9; dst_addr = 2'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rrun_busy", 32'(busy), 32'd0);
        chk("rrun_wren", 32'(wr_en), 32'd0);
        chk("rrun_dat", 32'(dat_out), 32'd0);
        chk("rrun_addr", 32'(wr_addr), 32'd0);
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (wr_en) pulses++;
        end
        chk("rrun_pulses", 32'(pulses), 32'd0);

        do_op(DIVR, 8'hFF, 8'h80, 2'd3, 8'h7F, 8, "pre_rwb");

        // Reset sampled on the edge that would enter WB.
        @(negedge clk);
        op = MULLO; opA = 8'd9; opB = 8'd9; dst_addr = 2'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rwb_busy", 32'(busy), 32'd0);
        chk("rwb_wren", 32'(wr_en), 32'd0);
        chk("rwb_dat", 32'(dat_out), 32'd0);
        chk("rwb_addr", 32'(wr_addr), 32'd0);
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (wr_en) pulses++;
        end
        chk("rwb_pulses", 32'(pulses), 32'd0);

        do_op(MULLO, 8'd2, 8'd3, 2'd2, 8'h06, 8, "mul2x3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
